// File: rtl/softermax_stream.sv
// -----------------------------------------------------------------------------
// softermax_stream
//
// Element-serial softmax. One vector of VEC_SIZE signed fixed-point scores is
// accepted one element per beat. While accepting, the block keeps a running
// integer max m and a base-2 power sum that is rescaled online whenever m
// grows (Softermax style). The raw inputs are buffered. Once the vector is
// complete, each element's probability pow(x,m)/sum is produced by a
// restoring divider (one quotient bit per cycle) and emitted one per beat.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input element valid
//   in_ready   block accepts an element (high only while accumulating)
//   in_data    signed input score, BW bits with FW fraction bits
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  consumer accepts the output element
//   out_data   unsigned probability, Q0.OUT_BW
//   out_idx    element index of out_data
//   out_last   high with the final element of a vector
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and data stable until the transfer; ready may
// change freely and never depends on valid in the same cycle. The outputs here
// stay stable while out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module softermax_stream #(
  parameter int BW       = 8,
  parameter int FW       = 2,
  parameter int POW_BW   = 16,
  parameter int POW_FW   = 6,
  parameter int ACCUM_BW = 16,
  parameter int VEC_SIZE = 10,
  parameter int OUT_BW   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BW-1:0]           out_data,
  output logic [$clog2(VEC_SIZE)-1:0] out_idx,
  output logic                        out_last
);

  // Widths
  localparam int MW  = BW - FW + 1;                 // integer max, signed
  localparam int DW  = BW + 2;                      // x - (m<<FW), signed
  localparam int CW  = $clog2(VEC_SIZE);            // element counters
  localparam int RW  = ((POW_BW > ACCUM_BW) ? POW_BW : ACCUM_BW) + 1;
  localparam int DCW = $clog2(OUT_BW + 2) + 1;      // divider step counter

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state_q, state_nx;

  // ---------------------------------------------------------------------------
  // Base-2 power term: 2^(x/2^FW - m) with a linear fraction approximation.
  // The integer part of the (non-positive) exponent becomes a right shift.
  // ---------------------------------------------------------------------------
  function automatic logic [POW_BW-1:0] pow_term(
    input logic signed [BW-1:0] x,
    input logic signed [MW-1:0] m
  );
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] i;
    logic        [DW-1:0] sh;
    logic        [FW-1:0] f;
    logic    [POW_BW-1:0] base;
    d    = DW'(x) - (DW'(m) <<< FW);
    i    = d >>> FW;
    f    = d[FW-1:0];
    sh   = -i;
    base = (POW_BW'(1) << POW_FW) | (POW_BW'(f) << (POW_FW - FW));
    if (int'(sh) >= POW_BW) begin
      return '0;
    end
    return base >> sh;
  endfunction

  // Saturating accumulate into the ACCUM_BW sum.
  function automatic logic [ACCUM_BW-1:0] sat_add(
    input logic [ACCUM_BW-1:0] a,
    input logic [POW_BW-1:0]   b
  );
    logic [RW-1:0] s;
    s = RW'(a) + RW'(b);
    if (s > RW'({ACCUM_BW{1'b1}})) begin
      return '1;
    end
    return ACCUM_BW'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [BW-1:0]              vbuf [VEC_SIZE];
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              k_q;
  logic signed [MW-1:0]       m_q;
  logic [ACCUM_BW-1:0]        sum_q;
  logic [DCW-1:0]             dcnt_q;
  logic [RW-1:0]              rem_q;
  logic [OUT_BW-1:0]          q_q;
  logic                       ovf_q;

  // ---------------------------------------------------------------------------
  // Online max / sum update for the element on in_data
  // ---------------------------------------------------------------------------
  logic signed [BW-1:0]   in_x;
  logic signed [BW:0]     xc;
  logic signed [MW-1:0]   mx;
  logic [MW:0]            sh_amt;
  logic [POW_BW-1:0]      pw_at_m;
  logic [POW_BW-1:0]      pw_at_mx;
  logic [ACCUM_BW-1:0]    rescaled;
  logic signed [MW-1:0]   m_nx;
  logic [ACCUM_BW-1:0]    sum_nx;
  logic                   accept;
  logic                   accept_last;

  always_comb begin
    in_x     = in_data;
    // ceil(x/2^FW): bias by 2^FW-1 then floor via arithmetic shift
    xc       = (BW+1)'(in_x) + (BW+1)'((1 << FW) - 1);
    mx       = MW'(xc >>> FW);
    sh_amt   = (MW+1)'(mx) - (MW+1)'(m_q);
    pw_at_m  = pow_term(in_x, m_q);
    pw_at_mx = pow_term(in_x, mx);
    rescaled = (int'(sh_amt) >= ACCUM_BW) ? '0 : (sum_q >> sh_amt);
    m_nx     = m_q;
    sum_nx   = sum_q;
    if (cnt_q == '0) begin
      m_nx   = mx;
      sum_nx = sat_add('0, pw_at_mx);
    end else if (mx > m_q) begin
      // New max: old terms were relative to the smaller m, scale them down
      m_nx   = mx;
      sum_nx = sat_add(rescaled, pw_at_mx);
    end else begin
      sum_nx = sat_add(sum_q, pw_at_m);
    end
  end

  assign accept      = in_valid && (state_q == ACCUM);
  assign accept_last = accept && (cnt_q == CW'(VEC_SIZE - 1));

  // ---------------------------------------------------------------------------
  // Divider datapath: step 0 loads p, steps 1..OUT_BW make one quotient bit
  // each, step OUT_BW+1 applies saturation.
  // ---------------------------------------------------------------------------
  logic [POW_BW-1:0] p_div;
  logic [RW-1:0]     rem_sh;
  logic              rem_ge;
  logic              div_done;
  logic              out_hs;
  logic              k_last;

  always_comb begin
    p_div    = pow_term(vbuf[k_q], m_q);
    rem_sh   = rem_q << 1;
    rem_ge   = rem_sh >= RW'(sum_q);
    div_done = (dcnt_q == DCW'(OUT_BW + 1));
    k_last   = (k_q == CW'(VEC_SIZE - 1));
    out_hs   = out_ready && (state_q == OUT);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept_last) state_nx = DIV;
      end
      DIV: begin
        if (div_done) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = q_q;
        out_idx   = k_q;
        out_last  = k_last;
        if (out_ready) state_nx = k_last ? ACCUM : DIV;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input buffer: contents are only read after a full vector was written, so
  // it needs no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      vbuf[cnt_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator, counters and divider registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      k_q    <= '0;
      m_q    <= '0;
      sum_q  <= '0;
      dcnt_q <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            m_q   <= m_nx;
            sum_q <= sum_nx;
            cnt_q <= accept_last ? '0 : cnt_q + 1'b1;
          end
          if (accept_last) begin
            k_q    <= '0;
            dcnt_q <= '0;
          end
        end
        DIV: begin
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == '0) begin
            // A quotient >= 2^OUT_BW happens exactly when p >= sum
            rem_q <= RW'(p_div);
            ovf_q <= RW'(p_div) >= RW'(sum_q);
            q_q   <= '0;
          end else if (!div_done) begin
            if (!ovf_q) begin
              rem_q <= rem_ge ? (rem_sh - RW'(sum_q)) : rem_sh;
              q_q   <= (q_q << 1) | OUT_BW'(rem_ge);
            end
          end else if (ovf_q) begin
            q_q <= '1;
          end
        end
        OUT: begin
          if (out_hs) begin
            dcnt_q <= '0;
            if (k_last) begin
              k_q   <= '0;
              cnt_q <= '0;
              m_q   <= '0;
              sum_q <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: begin
          dcnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softermax_stream.sv
// -----------------------------------------------------------------------------
// tb_softermax_stream: directed, table-driven bench for softermax_stream.
// Each table record holds one ten-element input vector and the ten expected
// probabilities, computed by hand from the fixed-point definition.
// -----------------------------------------------------------------------------
module tb_softermax_stream;

  localparam int LAT = 18;  // OUT_BW + 2

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;

  softermax_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [79:0]  din;   // element i at [i*8 +: 8]
    logic [159:0] expv;  // expected probability i at [i*16 +: 16]
  } vec_t;

  vec_t tbl [6];

  // ---------------- driver tasks ----------------
  // Starts and ends at a negedge; acc_cyc is the edge that took the last element.
  task automatic send(input logic [79:0] dv, input int n, input bit bubbles,
                      output int acc_cyc);
    for (int i = 0; i < n; i++) begin
      if (bubbles && (i % 3 == 1)) begin
        in_valid = 1'b0;
        in_data  = 8'h7F;
        repeat (2) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = dv[i*8 +: 8];
      chk("in_ready_accum", int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic collect(input logic [159:0] expv, input int stall_idx,
                         input int stall_len, input int start_cyc);
    int ref_cyc;
    ref_cyc = start_cyc;
    // Junk on the input side must be ignored until the vector is drained.
    in_valid = 1'b1;
    in_data  = 8'h7F;
    for (int i = 0; i < 10; i++) begin
      int t;
      int ev;
      t  = 0;
      ev = int'(expv[i*16 +: 16]);
      out_ready = (i != stall_idx);
      while (!out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid_seen", int'(out_valid), 1);
      chk("latency", cyc - ref_cyc, LAT);
      chk("out_data", int'(out_data), ev);
      chk("out_idx", int'(out_idx), i);
      chk("out_last", int'(out_last), (i == 9) ? 1 : 0);
      chk("in_ready_busy", int'(in_ready), 0);
      if (i == stall_idx) begin
        repeat (stall_len) begin
          @(negedge clk);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_data", int'(out_data), ev);
          chk("hold_idx", int'(out_idx), i);
          chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      ref_cyc = cyc + 1;  // handshake on the coming edge
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("in_ready_after_last", int'(in_ready), 1);
    chk("out_valid_after_last", int'(out_valid), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc;

    tbl[0].din  = {10{8'h00}};
    tbl[0].expv = {10{16'd6553}};
    tbl[1].din  = {{9{8'h00}}, 8'h0C};
    tbl[1].expv = {{9{16'd3855}}, 16'd30840};
    tbl[2].din  = {{8{8'h00}}, 8'h04, 8'h00};
    tbl[2].expv = {{8{16'd5957}}, 16'd11915, 16'd5957};
    tbl[3].din  = {10{8'hFC}};
    tbl[3].expv = {10{16'd6553}};
    tbl[4].din  = {{9{8'h00}}, 8'h0E};
    tbl[4].expv = {{9{16'd3120}}, 16'd37449};
    tbl[5].din  = {{8{8'h80}}, 8'h7C, 8'h80};
    tbl[5].expv = {{8{16'd0}}, 16'd65535, 16'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    chk("reset_out_last", int'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);

    // Table-driven vectors, no stalls
    for (int v = 0; v < 6; v++) begin
      send(tbl[v].din, 10, 1'b0, acc);
      collect(tbl[v].expv, -1, 0, acc);
    end

    // Input bubbles plus output backpressure on idx 3
    send(tbl[2].din, 10, 1'b1, acc);
    collect(tbl[2].expv, 3, 20, acc);

    // Reset in the middle of DIV
    send(tbl[1].din, 10, 1'b0, acc);
    repeat (5) @(negedge clk);
    chk("mid_div_busy", int'(in_ready), 0);
    pulse_reset();
    send(tbl[0].din, 10, 1'b0, acc);
    collect(tbl[0].expv, -1, 0, acc);

    // Reset in the middle of ACCUM, with a max-raising partial vector
    send(tbl[1].din, 4, 1'b0, acc);
    pulse_reset();
    send(tbl[0].din, 10, 1'b0, acc);
    collect(tbl[0].expv, -1, 0, acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
